div_unit: RTL and testbench

- Multi-cycle integer divider for the execute stage. It serves DIV/DIVU.
- Accepts operands when the divide instruction is in E and raises a stall request, which feeds the pipeline's stallE, while iterating.
- Delivers quotient and remainder with a one-cycle write-enable to the HI/LO registers: quotient to LO, remainder to HI.
- Radix-2 restoring division, one quotient bit per cycle.

---
 rtl/cpu_defs.sv | 19 +
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared across the execute-stage units.
//   DIV_WIDTH  - default datapath width of the divider.
//   divState_t - divider FSM state encoding.
//   DIV_ZERO_Q - quotient returned for a divide by zero (all ones).
// ---------------------------------------------------------------------------
package cpu_defs;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } divState_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one radix-2 restoring-division iteration (combinational).
//   acc      in  WIDTH  partial remainder, always < divisor
//   divisor  in  WIDTH  divisor magnitude
//   inBit    in  1      next dividend bit shifted into the remainder
//   accNext  out WIDTH  updated partial remainder
//   qBit     out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] divisor,
   input  logic             inBit,
   output logic [WIDTH-1:0] accNext,
   output logic             qBit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // One extra bit so the shifted remainder can exceed the divisor range.
   assign shifted = {acc, inBit};
   assign diff    = shifted - {1'b0, divisor};

   // No borrow out of the subtraction means shifted >= divisor.
   assign qBit    = ~diff[WIDTH];

   // acc < divisor on entry, so the difference always fits in WIDTH bits.
   assign accNext = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit: multi-cycle DIV/DIVU unit for the execute stage.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with signs restored when the result is written.
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-low reset
//   startE   in  1      divide instruction valid in E
//   signedE  in  1      1 = DIV (signed), 0 = DIVU
//   opaE     in  WIDTH  dividend (rs)
//   opbE     in  WIDTH  divisor (rt)
//   flushE   in  1      cancel any operation in progress
//   busy     out 1      stall request (feeds stallE)
//   done     out 1      one-cycle pulse, results valid
//   hilo_we  out 1      HI/LO write enable (equals done)
//   lo_o     out WIDTH  quotient
//   hi_o     out WIDTH  remainder
// ---------------------------------------------------------------------------
module div_unit
   import cpu_defs::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6           // 2**CNT_W must exceed WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] opaE,
   input  logic [WIDTH-1:0] opbE,
   input  logic             flushE,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   divState_t        state, stateNext;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] acc;        // partial remainder
   logic [WIDTH-1:0] dividend;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] divisor;
   logic             qNeg, rNeg;

   logic             aNeg, bNeg;
   logic [WIDTH-1:0] absA, absB;
   logic [WIDTH-1:0] accStep;
   logic             qBit;
   logic             lastStep;
   logic             accept;
   logic             divZero;
   logic [WIDTH-1:0] qFinal;

   assign aNeg     = signedE & opaE[WIDTH-1];
   assign bNeg     = signedE & opbE[WIDTH-1];
   // 0x80..0 negates to itself, which is its correct unsigned magnitude.
   assign absA     = aNeg ? -opaE : opaE;
   assign absB     = bNeg ? -opbE : opbE;
   assign divZero  = (opbE == '0);
   assign accept   = (state == IDLE) & startE & ~flushE;
   assign lastStep = (count == CNT_W'(WIDTH - 1));
   assign qFinal   = {dividend[WIDTH-2:0], qBit};

   div_step #(.WIDTH(WIDTH)) uStep (
      .acc     (acc),
      .divisor (divisor),
      .inBit   (dividend[WIDTH-1]),
      .accNext (accStep),
      .qBit    (qBit)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startE) stateNext = divZero ? DONE : RUN;
         RUN:     if (lastStep) stateNext = DONE;
         DONE:    stateNext = IDLE;   // same instruction may still be in E
         default: stateNext = IDLE;
      endcase
      if (flushE) stateNext = IDLE;
   end

   // Outputs; busy drops in DONE so the instruction can retire that cycle.
   always_comb begin
      busy    = (((state == IDLE) & startE) | (state == RUN)) & ~flushE;
      done    = (state == DONE) & ~flushE;
      hilo_we = done;
   end

   // Datapath; results are registered only on entry to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         acc      <= '0;
         dividend <= '0;
         divisor  <= '0;
         qNeg     <= 1'b0;
         rNeg     <= 1'b0;
         lo_o     <= '0;
         hi_o     <= '0;
      end else if (accept) begin
         count    <= '0;
         acc      <= '0;
         dividend <= absA;
         divisor  <= absB;
         qNeg     <= aNeg ^ bNeg;
         rNeg     <= aNeg;
         if (divZero) begin
            // Replicated so the pattern scales with WIDTH.
            lo_o <= {WIDTH{DIV_ZERO_Q[0]}};
            hi_o <= opaE;
         end
      end else if ((state == RUN) && !flushE) begin
         count    <= count + 1'b1;
         acc      <= accStep;
         dividend <= qFinal;
         if (lastStep) begin
            lo_o <= qNeg ? -qFinal : qFinal;
            hi_o <= rNeg ? -accStep : accStep;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        startE = 1'b0;
   logic        signedE = 1'b0;
   logic [31:0] opaE = '0;
   logic [31:0] opbE = '0;
   logic        flushE = 1'b0;
   logic        busy, done, hilo_we;
   logic [31:0] lo_o, hi_o;

   int passCnt = 0;
   int totalCnt = 0;

   logic [63:0] scoreboard[$];     // {lo, hi} expected per accepted start
   logic [31:0] lastLo = '0;       // bench's view of the HI/LO outputs
   logic [31:0] lastHi = '0;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .startE  (startE),
      .signedE (signedE),
      .opaE    (opaE),
      .opbE    (opbE),
      .flushE  (flushE),
      .busy    (busy),
      .done    (done),
      .hilo_we (hilo_we),
      .lo_o    (lo_o),
      .hi_o    (hi_o)
   );

   always #5 clk = ~clk;

   // Runs one divide: start cycle, wait for done, compare against scoreboard.
   task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] expLo, input logic [31:0] expHi,
                         input int expLat, input string name, input logic holdStart);
      int  n;
      logic got, busyOk, holdOk;
      logic [63:0] exp;
      @(negedge clk);
      opaE = a; opbE = b; signedE = s; startE = 1'b1;
      #1;
      totalCnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL %s start: busy=%b done=%b, required busy=1 done=0", name, busy, done);
      else passCnt++;
      totalCnt++;
      if (lo_o !== lastLo || hi_o !== hiLast())
         $display("FAIL %s hold@start: lo=%h hi=%h, required lo=%h hi=%h", name, lo_o, hi_o, lastLo, lastHi);
      else passCnt++;
      scoreboard.push_back({expLo, expHi});
      @(posedge clk); #1;
      if (!holdStart) startE = 1'b0;
      n = 0; got = 1'b0; busyOk = 1'b1; holdOk = 1'b1;
      while (n < 60 && !got) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) got = 1'b1;
         else begin
            if (busy !== 1'b1) busyOk = 1'b0;
            if (lo_o !== lastLo || hi_o !== lastHi) holdOk = 1'b0;
         end
      end
      totalCnt++;
      if (!got) begin
         $display("FAIL %s timeout: no done within 60 cycles, required done at cycle %0d", name, expLat);
         return;
      end else passCnt++;
      totalCnt++;
      if (n != expLat || !busyOk)
         $display("FAIL %s latency: done at %0d busyOk=%b, required %0d busyOk=1", name, n, busyOk, expLat);
      else passCnt++;
      totalCnt++;
      if (!holdOk)
         $display("FAIL %s hold: outputs changed before done, required %h/%h", name, lastLo, lastHi);
      else passCnt++;
      totalCnt++;
      if (hilo_we !== 1'b1 || busy !== 1'b0)
         $display("FAIL %s done_cycle: hilo_we=%b busy=%b, required hilo_we=1 busy=0", name, hilo_we, busy);
      else passCnt++;
      exp = scoreboard.pop_front();
      totalCnt++;
      if (lo_o !== exp[63:32] || hi_o !== exp[31:0])
         $display("FAIL %s result: lo=%h hi=%h, required lo=%h hi=%h", name, lo_o, hi_o, exp[63:32], exp[31:0]);
      else passCnt++;
      $display("txn %s: a=%h b=%h s=%b lo=%h hi=%h latency=%0d", name, a, b, s, lo_o, hi_o, n);
      lastLo = exp[63:32];
      lastHi = exp[31:0];
      if (holdStart) begin
         @(posedge clk); #1;
         startE = 1'b0;
      end
   endtask

   function automatic logic [31:0] hiLast();
      return lastHi;
   endfunction

   // Independent reference using the language's signed/unsigned operators.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (s) begin
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      totalCnt++;
      if (busy !== 1'b0 || done !== 1'b0 || hilo_we !== 1'b0 || lo_o !== 32'h0 || hi_o !== 32'h0)
         $display("FAIL reset: busy=%b done=%b we=%b lo=%h hi=%h, required all 0", busy, done, hilo_we, lo_o, hi_o);
      else passCnt++;
      $display("txn reset: busy=%b done=%b lo=%h hi=%h", busy, done, lo_o, hi_o);
      rst = 1'b1;
   endtask

   task automatic test_unsigned();
      runDiv(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, "udiv_100_7", 1'b0);
      runDiv(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33, "udiv_max_1", 1'b0);
   endtask

   task automatic test_signed();
      runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "sdiv_m7_2", 1'b0);
      runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, "sdiv_7_m2", 1'b0);
      runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, "sdiv_ovf", 1'b0);
   endtask

   task automatic test_div_zero();
      runDiv(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1, "div_zero_u", 1'b0);
      runDiv(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, "div_zero_s", 1'b0);
   endtask

   task automatic test_flush();
      int doneSeen = 0;
      logic holdOk = 1'b1;
      @(negedge clk);
      opaE = 32'd100; opbE = 32'd7; signedE = 1'b0; startE = 1'b1;
      @(posedge clk); #1;
      startE = 1'b0;
      repeat (9) @(posedge clk);
      #1 flushE = 1'b1;
      @(negedge clk);
      totalCnt++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL flush_busy: busy=%b done=%b, required 0 0", busy, done);
      else passCnt++;
      @(posedge clk); #1;
      flushE = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
         if (lo_o !== lastLo || hi_o !== lastHi) holdOk = 1'b0;
      end
      totalCnt++;
      if (doneSeen != 0 || !holdOk)
         $display("FAIL flush_nodone: done count=%0d holdOk=%b, required 0 and 1", doneSeen, holdOk);
      else passCnt++;
      $display("txn flush: done count=%0d lo=%h hi=%h", doneSeen, lo_o, hi_o);
      runDiv(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, "after_flush_9_3", 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, q, r;
      logic s;
      for (int i = 0; i < 4; i++) begin
         s = i[0];
         a = $urandom;
         b = $urandom_range(1, 1000);
         if (i == 3) b = $urandom;
         if (s && b == 32'hFFFF_FFFF && a == 32'h8000_0000) a = 32'd1;
         if (b == 0) b = 32'd3;
         model(a, b, s, q, r);
         runDiv(a, b, s, q, r, 33, $sformatf("b2b_%0d", i), 1'b0);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      opaE = 32'd100; opbE = 32'd7; signedE = 1'b0; startE = 1'b1;
      @(posedge clk); #1;
      startE = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      totalCnt++;
      if (busy !== 1'b0 || done !== 1'b0 || lo_o !== 32'h0 || hi_o !== 32'h0)
         $display("FAIL async_reset: busy=%b done=%b lo=%h hi=%h, required all 0", busy, done, lo_o, hi_o);
      else passCnt++;
      $display("txn async_reset: busy=%b lo=%h hi=%h", busy, lo_o, hi_o);
      lastLo = '0; lastHi = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_held_start();
      int doneSeen = 0;
      logic idleOk = 1'b1;
      runDiv(32'd6, 32'd2, 1'b0, 32'd3, 32'd0, 33, "held_start", 1'b1);
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
         if (busy !== 1'b0) idleOk = 1'b0;
      end
      totalCnt++;
      if (doneSeen != 0 || !idleOk)
         $display("FAIL held_restart: extra done=%0d idleOk=%b, required 0 and 1", doneSeen, idleOk);
      else passCnt++;
      $display("txn held_start_tail: extra done=%0d", doneSeen);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_held_start();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
